// File: rtl/lsrt_pkg.sv
// Shared constants for the lstx arbiter and its transmitter.
package lsrt_pkg;

  localparam logic [7:0] TMO_DEF = 8'd200;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    PUSH,
    WAIT_BUSY,
    WAIT_DONE,
    DONE,
    ERR
  } arb_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lstx_arb.sv
// Arbitrates NREQ requesters onto one transmitter using
// toggle handshakes for push and clear.
module lstx_arb
  import lsrt_pkg::*;
#(
  parameter int         NREQ = 4,
  parameter int         DMSB = 9,
  parameter int         TMSB = 7,
  parameter logic [TMSB:0] TMO = TMO_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       setn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*(DMSB+1)-1:0]   req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic                       busy,
  output logic                       err,
  output logic                       tx_push,
  output logic                       tx_clear,
  output logic [DMSB:0]              tx_wdata,
  input  logic                       tx_empty
);

  localparam int DW = DMSB + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            push_q, push_d;
  logic            clr_q, clr_d;
  logic [DMSB:0]   wdata_q, wdata_d;
  logic [TMSB:0]   tmr_q, tmr_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [DMSB:0]   words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_wdata[i*DW +: DW];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    push_d  = push_q;
    clr_d   = clr_q;
    wdata_d = wdata_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (|req && tx_empty) state_d = ARB;
      end
      ARB: begin
        // A request withdrawn since IDLE leaves nothing to serve.
        if (pick_vld) begin
          idx_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          wdata_d = words[pick_idx];
          state_d = PUSH;
        end else begin
          state_d = IDLE;
        end
      end
      PUSH: begin
        push_d  = ~push_q;
        tmr_d   = TMO;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_empty) state_d = WAIT_DONE;
        else if (tmr_q == '0) state_d = ERR;
        else tmr_d = tmr_q - 1'b1;
      end
      WAIT_DONE: begin
        if (tx_empty) state_d = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = idx_q;
        state_d = IDLE;
      end
      ERR: begin
        clr_d   = ~clr_q;
        gnt_d   = '0;
        ptr_d   = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      push_q  <= 1'b0;
      clr_q   <= 1'b0;
      wdata_q <= '0;
      tmr_q   <= '0;
    end else if (setn) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      push_q  <= push_d;
      clr_q   <= clr_d;
      wdata_q <= wdata_d;
      tmr_q   <= tmr_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = (state_q == DONE) ? gnt_q : '0;
  assign err      = (state_q == ERR);
  assign busy     = (state_q != IDLE);
  assign tx_push  = push_q;
  assign tx_clear = clr_q;
  assign tx_wdata = wdata_q;

endmodule

// File: tb/tb_lstx_arb.sv
// Bench for lstx_arb: transmitter model, monitor and
// round-robin reference model.
module tb_lstx_arb;

  localparam int NREQ = 4;
  localparam int DW   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              setn;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              err;
  logic              tx_push;
  logic              tx_clear;
  logic [DW-1:0]     tx_wdata;
  logic              tx_empty;

  logic mdl_empty = 1'b1;
  logic ext_busy  = 1'b0;
  assign tx_empty = mdl_empty & ~ext_busy;

  lstx_arb #(
    .NREQ (NREQ),
    .DMSB (DW - 1),
    .TMSB (7),
    .TMO  (8'd200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .setn      (setn),
    .req       (req),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy),
    .err       (err),
    .tx_push   (tx_push),
    .tx_clear  (tx_clear),
    .tx_wdata  (tx_wdata),
    .tx_empty  (tx_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ptr = NREQ - 1;

  always @(posedge clk) cyc++;

  // Transmitter model: busy_dly cycles after a push toggle it
  // drops empty, holds it low for frame_len cycles.
  int busy_dly = 3;
  int frame_len = 8;
  bit never_busy = 0;
  logic m_push = 1'b0;
  logic m_clr = 1'b0;
  int phase = 0;
  int mcnt = 0;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_push = 1'b0;
      m_clr = 1'b0;
      mdl_empty = 1'b1;
      phase = 0;
      mcnt = 0;
    end else begin
      if (tx_clear !== m_clr) begin
        m_clr = tx_clear;
        mdl_empty = 1'b1;
        phase = 0;
      end
      if (tx_push !== m_push) begin
        m_push = tx_push;
        phase = 1;
        mcnt = 0;
      end else if (phase == 1) begin
        mcnt++;
        if (!never_busy && mcnt >= busy_dly) begin
          mdl_empty = 1'b0;
          phase = 2;
          mcnt = 0;
        end
      end else if (phase == 2) begin
        mcnt++;
        if (mcnt >= frame_len) begin
          mdl_empty = 1'b1;
          phase = 0;
        end
      end
    end
  end

  // Monitor
  int grants[$];
  int acks[$];
  logic [DW-1:0] words[$];
  logic mon_push = 1'b0;
  logic [NREQ-1:0] mon_gnt = '0;
  int last_push_cyc = -1;
  int min_gap = 1000000;
  int err_cnt = 0;
  int err_cyc = 0;
  int bad_onehot = 0;
  int bad_ack = 0;

  function automatic int oh2i(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_push = tx_push;
      mon_gnt = gnt;
      last_push_cyc = -1;
    end else begin
      if (tx_push !== mon_push) begin
        mon_push = tx_push;
        words.push_back(tx_wdata);
        if (last_push_cyc >= 0 && cyc - last_push_cyc < min_gap)
          min_gap = cyc - last_push_cyc;
        last_push_cyc = cyc;
      end
      if (gnt != 0 && mon_gnt == 0) grants.push_back(oh2i(gnt));
      if ($countones(gnt) > 1) bad_onehot++;
      if (ack != 0) begin
        acks.push_back(oh2i(ack));
        if ((ack & ~gnt) != 0 || $countones(ack) != 1) bad_ack++;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      mon_gnt = gnt;
    end
  end

  // Reference: first pending requester after last served.
  function automatic int rr_next(input bit [NREQ-1:0] pend,
                                 input int last);
    for (int k = 1; k <= NREQ; k++)
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  task automatic wait_ack(input int maxc, output bit to);
    to = 1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = NREQ - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setn = 1'b1;
    req = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 4'b0) begin
      $display("FAIL rst_gnt got %b want 0000", gnt);
      errors++;
    end
    checks++;
    if (ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_flags ack %b err %b busy %b want 0", ack, err, busy);
      errors++;
    end
    checks++;
    if (tx_push !== 1'b0 || tx_clear !== 1'b0) begin
      $display("FAIL rst_tog push %b clr %b want 0", tx_push, tx_clear);
      errors++;
    end
    checks++;
    if (tx_wdata !== 10'h0) begin
      $display("FAIL rst_wdata got %h want 000", tx_wdata);
      errors++;
    end
    rst = 1'b0;
    exp_ptr = NREQ - 1;
  endtask

  task automatic test_single();
    bit to;
    busy_dly = 3;
    frame_len = 8;
    acks.delete();
    req_wdata[9:0] = 10'h155;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b1) begin
      $display("FAIL lat_arb gnt %b busy %b want 0000 1", gnt, busy);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || tx_push !== 1'b0) begin
      $display("FAIL lat_gnt gnt %b push %b want 0001 0", gnt, tx_push);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (tx_push !== 1'b1 || tx_wdata !== 10'h155) begin
      $display("FAIL lat_push push %b wdata %h want 1 155", tx_push, tx_wdata);
      errors++;
    end
    wait_ack(100, to);
    checks++;
    if (to || ack !== 4'b0001) begin
      $display("FAIL single_ack got %b to %0d want 0001", ack, to);
      errors++;
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0 || acks.size() != 1) begin
      $display("FAIL single_end ack %b busy %b n %0d want 0 0 1",
               ack, busy, acks.size());
      errors++;
    end
    exp_ptr = 0;
  endtask

  task automatic test_idle_busy();
    bit to;
    int bad;
    bad = 0;
    ext_busy = 1'b1;
    req = 4'b0001;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || gnt !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL idle_hold got %0d bad cycles want 0", bad);
      errors++;
    end
    ext_busy = 1'b0;
    wait_ack(100, to);
    checks++;
    if (to || ack !== 4'b0001) begin
      $display("FAIL idle_ack got %b want 0001", ack);
      errors++;
    end
    req = '0;
    exp_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit to;
    int e;
    logic [DW-1:0] w [NREQ];
    do_reset();
    grants.delete();
    words.delete();
    busy_dly = 2;
    frame_len = 3;
    for (int i = 0; i < NREQ; i++) begin
      w[i] = rnd_word();
      req_wdata[i*DW +: DW] = w[i];
    end
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_ack(100, to);
      if (to) break;
    end
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (grants.size() != 8 || words.size() != 8) begin
      $display("FAIL rr_count grants %0d words %0d want 8",
               grants.size(), words.size());
      errors++;
    end else begin
      for (int f = 0; f < 8; f++) begin
        e = rr_next(4'b1111, exp_ptr);
        checks++;
        if (grants[f] != e || words[f] !== w[e]) begin
          $display("FAIL rr_order frame %0d got %0d/%h want %0d/%h",
                   f, grants[f], words[f], e, w[e]);
          errors++;
        end
        exp_ptr = e;
      end
    end
  endtask

  task automatic test_random();
    bit to;
    bit [NREQ-1:0] pend;
    int e;
    logic [DW-1:0] w [NREQ];
    min_gap = 1000000;
    for (int i = 0; i < NREQ; i++) begin
      w[i] = rnd_word();
      req_wdata[i*DW +: DW] = w[i];
    end
    pend = NREQ'($urandom_range(1, 15));
    req = pend;
    for (int f = 0; f < 24; f++) begin
      wait_ack(200, to);
      e = rr_next(pend, exp_ptr);
      checks++;
      if (to || ack !== NREQ'(1 << e) || words[$] !== w[e]) begin
        $display("FAIL rand_frame %0d ack %b word %h want %0d %h",
                 f, ack, words[$], e, w[e]);
        errors++;
      end
      if (to) break;
      exp_ptr = e;
      pend[e] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          w[i] = rnd_word();
          req_wdata[i*DW +: DW] = w[i];
        end
      end
      if (pend == 0) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
      busy_dly = $urandom_range(1, 4);
      frame_len = $urandom_range(1, 10);
      req = pend;
    end
    req = '0;
    repeat (20) @(negedge clk);
    checks++;
    if (min_gap < 5) begin
      $display("FAIL push_gap got %0d want >=5", min_gap);
      errors++;
    end
    checks++;
    if (bad_onehot != 0 || bad_ack != 0) begin
      $display("FAIL grant_shape onehot %0d ack %0d want 0 0",
               bad_onehot, bad_ack);
      errors++;
    end
    busy_dly = 3;
    frame_len = 8;
  endtask

  task automatic test_timeout();
    bit seen;
    logic clr0;
    int na;
    seen = 0;
    clr0 = tx_clear;
    never_busy = 1;
    err_cnt = 0;
    na = acks.size();
    req_wdata[19:10] = rnd_word();
    req = 4'b0010;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) begin
        seen = 1;
        break;
      end
    end
    req = '0;
    checks++;
    if (!seen || err_cyc - last_push_cyc != 201) begin
      $display("FAIL tmo_delay got %0d seen %0d want 201",
               err_cyc - last_push_cyc, seen);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || tx_clear !== ~clr0) begin
      $display("FAIL tmo_clear err %b clr %b want 0 %b", err, tx_clear, ~clr0);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || acks.size() != na || err_cnt != 1) begin
      $display("FAIL tmo_end busy %b acks %0d errs %0d want 0 %0d 1",
               busy, acks.size(), err_cnt, na);
      errors++;
    end
    never_busy = 0;
    exp_ptr = 1;
  endtask

  task automatic test_setn();
    bit to;
    int bad;
    logic p0;
    logic c0;
    logic [DW-1:0] w2;
    bad = 0;
    p0 = tx_push;
    c0 = tx_clear;
    busy_dly = 2;
    frame_len = 20;
    w2 = rnd_word();
    req_wdata[29:20] = w2;
    req = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_empty == 1'b0) break;
    end
    repeat (2) @(negedge clk);
    setn = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0100 || ack !== 4'b0 || err !== 1'b0 ||
          busy !== 1'b1 || tx_push !== ~p0 || tx_clear !== c0 ||
          tx_wdata !== w2) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL setn_freeze got %0d changed cycles want 0", bad);
      errors++;
    end
    setn = 1'b1;
    wait_ack(20, to);
    checks++;
    if (to || ack !== 4'b0100) begin
      $display("FAIL setn_ack got %b want 0100", ack);
      errors++;
    end
    req = '0;
    exp_ptr = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    bit to;
    bit [NREQ-1:0] pend;
    int e;
    acks.delete();
    busy_dly = 2;
    frame_len = 30;
    req = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_empty == 1'b0) break;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || tx_push !== 1'b0 || busy !== 1'b0 ||
        ack !== 4'b0 || err !== 1'b0 || acks.size() != 0) begin
      $display("FAIL rstmid gnt %b push %b busy %b ack %b err %b",
               gnt, tx_push, busy, ack, err);
      errors++;
    end
    rst = 1'b0;
    exp_ptr = NREQ - 1;
    frame_len = 5;
    pend = 4'b1100;
    req = pend;
    for (int f = 0; f < 2; f++) begin
      wait_ack(100, to);
      e = rr_next(pend, exp_ptr);
      checks++;
      if (to || ack !== NREQ'(1 << e)) begin
        $display("FAIL rstmid_order %0d got %b want %0d", f, ack, e);
        errors++;
      end
      exp_ptr = e;
      pend[e] = 1'b0;
      req = pend;
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop();
    bit to;
    bit seen;
    logic [DW-1:0] w1;
    seen = 0;
    busy_dly = 2;
    frame_len = 6;
    w1 = rnd_word();
    req_wdata[19:10] = w1;
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt == 4'b0010) begin
        seen = 1;
        break;
      end
    end
    req = '0;
    req_wdata[19:10] = ~w1;
    wait_ack(100, to);
    checks++;
    if (!seen || to || ack !== 4'b0010) begin
      $display("FAIL drop_ack got %b seen %0d want 0010", ack, seen);
      errors++;
    end
    checks++;
    if (words[$] !== w1 || tx_wdata !== w1) begin
      $display("FAIL drop_word got %h/%h want %h", words[$], tx_wdata, w1);
      errors++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_idle_busy();
    test_round_robin();
    test_random();
    test_timeout();
    test_setn();
    test_rst_mid();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lstx_arb.md
LSTX_ARB -- requirements
Module: lstx_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NREQ, 4, number of requesters.
  DMSB, 9, MSB of the frame word, matching the transmitter.
  TMSB, 7, MSB of the start-timeout counter.
  TMO, 8'd200, number of clk cycles to wait for the transmitter to leave empty.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single clock; all logic on posedge.
  rst, in, 1, synchronous active-high reset.
  setn, in, 1, enable; when low, every register holds its value.
  req, in, NREQ, per-requester level request, held until ack.
  req_wdata, in, NREQ*(DMSB+1), packed words; requester i occupies slice i.
  gnt, out, NREQ, one-hot grant, high from ARB through DONE.
  ack, out, NREQ, one-cycle pulse to the served requester on frame completion.
  busy, out, 1, high whenever the state is not IDLE.
  err, out, 1, one-cycle pulse on start timeout.
  tx_push, out, 1, toggle-handshake push to the transmitter.
  tx_clear, out, 1, toggle-handshake clear to the transmitter.
  tx_wdata, out, DMSB+1, registered word to the transmitter.
  tx_empty, in, 1, transmitter idle indication.
REQ-003 The block SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 tx_push and tx_clear SHALL be toggle signals: each event is a single level inversion, never a pulse.
REQ-005 The FSM states SHALL be IDLE, ARB, PUSH, WAIT_BUSY, WAIT_DONE, DONE and ERR; all transitions SHALL be gated by setn=1.
REQ-006 IDLE SHALL go to ARB when req is nonzero and tx_empty=1; otherwise it stays in IDLE.
REQ-007 ARB SHALL select the first asserted req after ptr in round-robin order (wrapping NREQ-1 to 0).
REQ-008 In ARB the block SHALL latch idx, set gnt[idx], load tx_wdata from slice idx, and go to PUSH.
REQ-009 PUSH SHALL invert tx_push, load the timer with TMO, and go to WAIT_BUSY.
REQ-010 WAIT_BUSY SHALL go to WAIT_DONE when tx_empty=0.
REQ-011 Otherwise WAIT_BUSY SHALL decrement the timer, and go to ERR when the timer is 0.
REQ-012 WAIT_DONE SHALL go to DONE when tx_empty=1, with no timeout, since frame length depends on the transmitter's divider.
REQ-013 DONE SHALL pulse ack[idx] for one cycle, clear gnt, set ptr=idx, and go to IDLE.
REQ-014 ERR SHALL invert tx_clear, pulse err for one cycle, clear gnt, set ptr=idx, and go to IDLE without asserting ack.
REQ-015 Latency SHALL be: req sampled in IDLE -> gnt after 1 cycle -> tx_push toggle after 2 cycles.
REQ-016 A requester dropping req while granted SHALL NOT abort the frame; ack still pulses.
REQ-017 req_wdata changes after ARB SHALL NOT affect tx_wdata.
REQ-018 Minimum spacing between consecutive push toggles SHALL be 5 cycles, so no toggle is lost in the transmitter's edge detector.
REQ-019 A single persistent requester SHALL be re-granted back-to-back.
REQ-020 With several requesters persistent, each requester SHALL be served at most once per NREQ grants.
REQ-021 If tx_empty=0 while in IDLE (an external clear or another transmitter user), the FSM SHALL wait in IDLE.

Reset
REQ-022 rst SHALL take priority over setn.
REQ-023 On rst: state=IDLE, gnt=0, ack=0, err=0, busy=0, tx_push=0, tx_clear=0, tx_wdata=0, timer=0, ptr=NREQ-1 (so requester 0 has first priority).
REQ-024 rst asserted mid-frame SHALL return the block to IDLE next cycle, with no ack or err; the transmitter is reset by its own reset.

Structure
REQ-025 FSM state encodings and the default TMO SHALL live in shared package lsrt_pkg, alongside the transmitter's state constants.
REQ-026 Round-robin selection SHALL be a purely combinational sub-module rr_pick (inputs req and ptr; outputs idx and valid), reusable by a future lsrx arbiter.

Verification
REQ-027 Reset, then req=4'b0001, word0=10'h155, with a transmitter model that asserts busy after 3 cycles -> gnt=0001 at cycle 1, tx_push toggles 0->1, tx_wdata=10'h155, ack[0] pulses once after empty returns to 1.
REQ-028 req=4'b1111 held continuously over 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-029 Transmitter model never drops empty, TMO=200 -> err pulses 201 cycles after the push toggle, tx_clear toggles, no ack, FSM back in IDLE.
REQ-030 setn=0 for 50 cycles during WAIT_DONE -> all outputs frozen; after setn=1, completion proceeds normally with ack.
REQ-031 rst pulse during WAIT_DONE with req=4'b0100 -> next cycle gnt=0 and tx_push=0; after release, requester 2 is re-served with ptr restarting from 3.
REQ-032 Requester 1 drops req and changes its word after grant -> frame carries the original word and ack[1] still pulses.
